alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked sequential ALU. Successor to the 4-bit combinational add/sub ALU.
//   Adds logic, shift and iterative multiply operations, plus status flags and registered outputs.
//   Uses valid/ready on both sides. Sits between the operand-fetch stage and the result writeback stage.
// PARAMETERS
//   WIDTH  4  operand/result width; must be >= 2
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands and op presented
//   in_ready   out  1      block accepts an operation this cycle
//   op         in   3      alu_op_e: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 MUL=7
//   a          in   WIDTH  operand A (unsigned/two's complement)
//   b          in   WIDTH  operand B; shift amount for SLL/SRL
//   out_valid  out  1      result and flags valid
//   out_ready  in   1      downstream consumes the result
//   result     out  WIDTH  registered result
//   carry_out  out  1      ADD: carry; SUB: carry of a+~b+1 (1 = no borrow); MUL: |high half; else 0
//   overflow   out  1      signed overflow for ADD/SUB; 0 for all other ops
//   zero       out  1      result == 0
//   negative   out  1      result[WIDTH-1]
//   busy       out  1      multiply in progress
// BEHAVIOUR
//   - Reset (async on rst_n=0): state IDLE; every output register and mul datapath register cleared to 0.
//     in_ready=1 from the first cycle after rst_n deasserts. A multiply in flight is discarded.
//   - FSM states IDLE, MUL, OUT.
//       IDLE: in_ready=1. Accept on in_valid&&in_ready.
//             op!=MUL -> compute the result, register it, go to OUT (latency 1 cycle).
//             op==MUL -> latch a and b, go to MUL.
//       MUL : shift-add, one bit of b per cycle, for WIDTH cycles; in_ready=0; busy=1.
//             Then register the low WIDTH bits and flags; go to OUT (latency WIDTH+1).
//       OUT : out_valid=1. result and flags stay stable while !out_ready.
//             out_ready=1 -> the result is consumed.
//             If another op is accepted in the same cycle, follow the IDLE rules; otherwise go to IDLE.
//   - in_ready = (state==IDLE) | (state==OUT & out_ready).
//     Single-cycle ops therefore stream at 1 op/cycle with out_ready held high.
//   - Operands and op are sampled only on acceptance. Input changes at any other time are ignored.
//   - Arithmetic is computed at WIDTH+1 bits. carry = bit WIDTH.
//     Overflow: ADD = (a[M]==b[M])&&(r[M]!=a[M]); SUB = (a[M]!=b[M])&&(r[M]!=a[M]); M = WIDTH-1.
//   - Shifts are logical. The amount is b[$clog2(WIDTH)-1:0] (one bit when WIDTH=2).
//     If the amount is >= WIDTH (non-power-of-2 WIDTH), the result is 0.
//   - MUL: full 2*WIDTH product, unsigned. result = low half; carry_out = |high half.
//   - zero and negative are always derived from the registered result.
//   - out_valid deasserts the cycle after consumption unless a new single-cycle op was accepted.
// STRUCTURE
//   - alu_pkg: typedef enum logic[2:0] alu_op_e; typedef enum state_e {IDLE,MUL,OUT}; op constants.
//   - Sub-module alu_mul_iter: iterative shift-add multiplier.
//     Ports: clk, rst_n, start, a, b, done, product[2*WIDTH].
//     Bit counter of width $clog2(WIDTH+1); done pulses 1 cycle.
//   - Top level: FSM, single-cycle combinational datapath, output/flag registers.
// TESTING (WIDTH=4, out_ready=1 unless noted)
//   1. ADD a=0011 b=0101 -> result 1000 c=0 v=1 n=1 z=0; out_valid 1 cycle after accept.
//   2. SUB a=1010 b=0011 -> result 0111 c=1 v=1 n=0; then SUB a=0010 b=0100 -> 1110 c=0 v=0 n=1.
//   3. ADD a=1111 b=0001 -> result 0000 c=1 z=1 v=0; streamed back-to-back after test 2.
//      in_ready stays 1 and there is one result per cycle.
//   4. MUL a=0111 b=0110 -> result 1010 c=1; in_ready=0 and busy=1 for 4 cycles; out_valid at accept+5.
//   5. SLL a=0011 b=0010 -> 1100; SRL a=1000 b=0011 -> 0001; XOR 1010^0110 -> 1100.
//   6. out_ready=0 for 3 cycles in OUT -> result/flags/out_valid stable, in_ready=0.
//      Then rst_n pulsed low mid-MUL -> all outputs 0 asynchronously, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encoding and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int OP_W    = 3;
  localparam int STATE_W = 2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one bit of b per cycle, done pulses once.
module alu_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= CW'(WIDTH);
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        // Last partial product lands on this edge; done follows in the next cycle.
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign busy    = r_busy;
  assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/logic/shift, iterative multiply,
// registered result and flags. Exposes its FSM state on dbg_state.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out,
  output logic               overflow,
  output logic               zero,
  output logic               negative,
  output logic               busy,
  output logic [STATE_W-1:0] dbg_state
);

  // Handshake: an operation is taken on a clock edge where in_valid && in_ready,
  // a result is consumed on an edge where out_valid && out_ready.

  localparam int M   = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH);

  state_e               r_state, w_next;
  alu_op_e              w_op;
  logic [WIDTH:0]       w_sum, w_diff;
  logic [SHW-1:0]       w_amt;
  logic [WIDTH-1:0]     w_res, w_reg_res;
  logic                 w_c, w_v, w_reg_c, w_reg_v;
  logic                 w_accept, w_mul_start, w_load_alu, w_load_mul;
  logic                 w_mul_done, w_mul_busy;
  logic [2*WIDTH-1:0]   w_product;

  logic [WIDTH-1:0]     r_result;
  logic                 r_valid, r_carry, r_ovf, r_zero, r_neg;

  assign w_op  = alu_op_e'(op);
  assign w_amt = b[SHW-1:0];

  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b};
    w_diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[M] == b[M]) && (w_sum[M] != a[M]);
      end
      OP_SUB: begin
        w_res = w_diff[M:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[M] != b[M]) && (w_diff[M] != a[M]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      // Amounts beyond the width only exist for non-power-of-2 WIDTH.
      OP_SLL: w_res = (int'(w_amt) >= WIDTH) ? '0 : (a << w_amt);
      OP_SRL: w_res = (int'(w_amt) >= WIDTH) ? '0 : (a >> w_amt);
      default: w_res = '0;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .busy    (w_mul_busy),
    .product (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  assign in_ready = (r_state == IDLE) || ((r_state == OUT) && out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_next      = r_state;
    w_mul_start = 1'b0;
    w_load_alu  = 1'b0;
    w_load_mul  = 1'b0;
    case (r_state)
      IDLE, OUT: begin
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            w_next      = MUL;
            w_mul_start = 1'b1;
          end else begin
            w_next     = OUT;
            w_load_alu = 1'b1;
          end
        end else if (r_state == OUT && out_ready) begin
          w_next = IDLE;
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_next     = OUT;
          w_load_mul = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_reg_res = w_load_mul ? w_product[WIDTH-1:0] : w_res;
  assign w_reg_c   = w_load_mul ? (|w_product[2*WIDTH-1:WIDTH]) : w_c;
  assign w_reg_v   = w_load_mul ? 1'b0 : w_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_load_alu || w_load_mul) begin
      r_result <= w_reg_res;
      r_valid  <= 1'b1;
      r_carry  <= w_reg_c;
      r_ovf    <= w_reg_v;
      r_zero   <= (w_reg_res == '0);
      r_neg    <= w_reg_res[M];
    end else if (r_state == OUT && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign busy      = w_mul_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=4): vector table, hand-written timing sequences and a random phase,
// all results checked through an expected-value queue.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero, negative, busy;
  logic [1:0]   dbg_state;

  logic         rand_rdy = 1'b0;
  logic         r_rand = 1'b1;
  logic         man_ready = 1'b1;
  assign out_ready = rand_rdy ? r_rand : man_ready;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 r_rand = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [7:0] pack(input logic [3:0] r, input logic c, input logic v);
    return {r, c, v, (r == 4'h0), r[3]};
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic logic [7:0] model(input alu_op_e o, input logic [3:0] x, input logic [3:0] y);
    int ux, uy, sx, sy, s, r, c, v;
    ux = int'(x); uy = int'(y);
    sx = x[3] ? ux - 16 : ux;
    sy = y[3] ? uy - 16 : uy;
    r = 0; c = 0; v = 0;
    case (o)
      OP_ADD: begin s = ux + uy; r = s % 16; c = s / 16; v = int'((sx + sy > 7) || (sx + sy < -8)); end
      OP_SUB: begin s = ux + (15 - uy) + 1; r = s % 16; c = s / 16; v = int'((sx - sy > 7) || (sx - sy < -8)); end
      OP_AND: r = ux & uy;
      OP_OR:  r = ux | uy;
      OP_XOR: r = ux ^ uy;
      OP_SLL: r = (ux << (uy % 4)) % 16;
      OP_SRL: r = ux >> (uy % 4);
      OP_MUL: begin s = ux * uy; r = s % 16; c = int'(s >= 16); end
      default: r = 0;
    endcase
    return pack(r[3:0], c[0], v[0]);
  endfunction

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input alu_op_e o, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] e, output int waits);
    logic rdy;
    in_valid = 1'b1; op = o; a = x; b = y; waits = 0;
    forever begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      waits++;
      if (waits > 100) break;
    end
    if (waits > 100) fail("accept_timeout");
    else exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); k++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail("unexpected_result");
      else chk("result_flags", {24'd0, result, carry_out, overflow, zero, negative}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    alu_op_e    op;
    logic [3:0] a, b, res;
    logic       c, v;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int waits;
    int busy_cnt;
    alu_op_e ro;

    tbl[0]  = '{OP_ADD, 4'h3, 4'h5, 4'h8, 1'b0, 1'b1};
    tbl[1]  = '{OP_SUB, 4'hA, 4'h3, 4'h7, 1'b1, 1'b1};
    tbl[2]  = '{OP_SUB, 4'h2, 4'h4, 4'hE, 1'b0, 1'b0};
    tbl[3]  = '{OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[4]  = '{OP_SLL, 4'h3, 4'h2, 4'hC, 1'b0, 1'b0};
    tbl[5]  = '{OP_SRL, 4'h8, 4'h3, 4'h1, 1'b0, 1'b0};
    tbl[6]  = '{OP_XOR, 4'hA, 4'h6, 4'hC, 1'b0, 1'b0};
    tbl[7]  = '{OP_AND, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
    tbl[8]  = '{OP_OR,  4'hC, 4'h3, 4'hF, 1'b0, 1'b0};
    tbl[9]  = '{OP_MUL, 4'h7, 4'h6, 4'hA, 1'b1, 1'b0};
    tbl[10] = '{OP_MUL, 4'h3, 4'h5, 4'hF, 1'b0, 1'b0};
    tbl[11] = '{OP_SUB, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0};
    tbl[12] = '{OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", {26'd0, result, carry_out, overflow}, 32'd0);
    chk("rst_flags", {29'd0, zero, negative, busy}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Single-cycle latency
    @(posedge clk); #1;
    send(OP_ADD, 4'h3, 4'h5, pack(4'h8, 1'b0, 1'b1), waits);
    @(negedge clk);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("add_valid_drop", 32'(out_valid), 32'd0);

    // Multiply timing
    @(posedge clk); #1;
    send(OP_MUL, 4'h7, 4'h6, pack(4'hA, 1'b1, 1'b0), waits);
    busy_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_out_valid", 32'(out_valid), 32'd0);
    end
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd4);
    @(negedge clk);
    chk("mul_latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Vector table, streamed back-to-back
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, pack(tbl[i].res, tbl[i].c, tbl[i].v), waits);
      if (i > 0 && tbl[i-1].op != OP_MUL) chk("stream_ready", 32'(waits), 32'd0);
    end
    drain();

    // Random ops with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ro = alu_op_e'($urandom_range(0, 7));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      send(ro, a, b, model(ro, a, b), waits);
    end
    rand_rdy = 1'b0;
    man_ready = 1'b1;
    drain();

    // Backpressure in OUT: result held, no new op taken
    man_ready = 1'b0;
    send(OP_ADD, 4'h5, 4'h6, pack(4'hB, 1'b0, 1'b1), waits);
    in_valid = 1'b1; op = 3'(OP_SUB); a = 4'h1; b = 4'h2;
    @(negedge clk);
    chk("stall_valid_first", 32'(out_valid), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", {26'd0, result, carry_out, overflow}, {26'd0, 4'hB, 1'b0, 1'b1});
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    man_ready = 1'b1;
    drain();

    // Reset in the middle of a multiply
    send(OP_MUL, 4'h3, 4'h5, pack(4'hF, 1'b0, 1'b0), waits);
    @(negedge clk);
    @(negedge clk);
    chk("mid_mul_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_outputs", {25'd0, out_valid, result, carry_out, overflow}, 32'd0);
    chk("async_rst_flags", {29'd0, zero, negative, busy}, 32'd0);
    chk("async_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(OP_ADD, 4'h1, 4'h2, pack(4'h3, 1'b0, 1'b0), waits);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
